// File: rtl/render_pkg.sv
// render_pkg: shared types and constants for the sprite renderer.
//   - colour constants (3-bit RGB-style palette)
//   - object_id encoding flag (MSB set = no sprite won the pixel)
//   - spr_cfg_t: per-sprite configuration {x, y, color, en}
package render_pkg;
  localparam int CRD_W = 10;  // coordinate width the config struct is built with
  localparam int CLR_W = 3;   // colour width the config struct is built with

  localparam logic [CLR_W-1:0] BLACK  = 3'b000;
  localparam logic [CLR_W-1:0] BLUE   = 3'b001;
  localparam logic [CLR_W-1:0] GREEN  = 3'b010;
  localparam logic [CLR_W-1:0] YELLOW = 3'b110;
  localparam logic [CLR_W-1:0] WHITE  = 3'b111;

  // object_id MSB: 1 means border or none. Low bits all ones = none,
  // all zeros = border.
  localparam logic ID_NOSPR = 1'b1;

  typedef struct packed {
    logic [CRD_W-1:0] x;
    logic [CRD_W-1:0] y;
    logic [CLR_W-1:0] color;
    logic             en;
  } spr_cfg_t;
endpackage

// File: rtl/sprite_hit.sv
// sprite_hit: one sprite's active config, bitmap and hit test.
//   clk, rst       : pixel clock, synchronous active-high reset
//   commit         : load cfg_nxt into the active config (frame_start)
//   cfg_nxt        : shadow config including any same-cycle write
//   pixel_x/y      : raw scan position (S0)
//   bmp_we/row/data: bitmap row write, bit 0 = leftmost pixel
//   hit, color     : registered S2 result for this sprite
module sprite_hit
  import render_pkg::*;
#(
  parameter int SPR_W = 8,
  parameter int SPR_H = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit,
  input  spr_cfg_t                 cfg_nxt,
  input  logic [CRD_W-1:0]         pixel_x,
  input  logic [CRD_W-1:0]         pixel_y,
  input  logic                     bmp_we,
  input  logic [$clog2(SPR_H)-1:0] bmp_row,
  input  logic [SPR_W-1:0]         bmp_data,
  output logic                     hit,
  output logic [CLR_W-1:0]         color
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  spr_cfg_t                     act;
  logic [SPR_H-1:0][SPR_W-1:0]  bmp;
  logic [CRD_W:0]               dx1, dy1;
  logic                         en1;
  logic [CLR_W-1:0]             col1;
  logic                         in_box, bmp_bit;

  always_ff @(posedge clk) begin
    if (rst)         act <= '0;
    else if (commit) act <= cfg_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)         bmp <= '0;
    else if (bmp_we) bmp[bmp_row] <= bmp_data;
  end

  // S1: offsets taken against the config active while the pixel is
  // sampled, so a commit in the same cycle only affects later pixels.
  // One extra bit keeps a pixel left of / above the sprite as a large
  // unsigned value instead of wrapping into range.
  always_ff @(posedge clk) begin
    dx1  <= {1'b0, pixel_x} - {1'b0, act.x};
    dy1  <= {1'b0, pixel_y} - {1'b0, act.y};
    col1 <= act.color;
  end

  always_ff @(posedge clk) begin
    if (rst) en1 <= 1'b0;
    else     en1 <= act.en;
  end

  // S2: bounds, bitmap bit, hit
  assign in_box  = (dx1 < (CRD_W+1)'(SPR_W)) && (dy1 < (CRD_W+1)'(SPR_H));
  assign bmp_bit = bmp[dy1[RW-1:0]][dx1[CW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) hit <= 1'b0;
    else     hit <= en1 && in_box && bmp_bit;
  end

  always_ff @(posedge clk) color <= col1;
endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: NUM_OBJ-sprite pixel renderer with optional border
// and per-frame collision reporting. Latency 3 cycles pixel -> object_*.
//   clk, rst                : pixel clock, synchronous active-high reset
//   pixel_x/y               : scan position
//   frame_start             : commits shadow config, closes collision window
//   cfg_we/idx/x/y/color/en : shadow config write
//   bmp_we/idx/row/data     : bitmap row write (immediate)
//   object_on/color/id      : rendered pixel (id MSB=1 -> border/none)
//   collision_mask/valid    : per-sprite overlap flags for the last frame
module sprite_renderer
  import render_pkg::*;
#(
  parameter int NUM_OBJ   = 4,
  parameter int SPR_W     = 8,
  parameter int SPR_H     = 8,
  parameter int COORD_W   = CRD_W,
  parameter int COLOR_W   = CLR_W,
  parameter int MAX_X     = 640,
  parameter int MAX_Y     = 480,
  parameter int BORDER_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COORD_W-1:0]         pixel_x,
  input  logic [COORD_W-1:0]         pixel_y,
  input  logic                       frame_start,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_OBJ)-1:0] cfg_idx,
  input  logic [COORD_W-1:0]         cfg_x,
  input  logic [COORD_W-1:0]         cfg_y,
  input  logic [COLOR_W-1:0]         cfg_color,
  input  logic                       cfg_en,
  input  logic                       bmp_we,
  input  logic [$clog2(NUM_OBJ)-1:0] bmp_idx,
  input  logic [$clog2(SPR_H)-1:0]   bmp_row,
  input  logic [SPR_W-1:0]           bmp_data,
  output logic                       object_on,
  output logic [COLOR_W-1:0]         object_color,
  output logic [$clog2(NUM_OBJ):0]   object_id,
  output logic [NUM_OBJ-1:0]         collision_mask,
  output logic                       collision_valid
);
  localparam int IDX_W = $clog2(NUM_OBJ);
  localparam logic [IDX_W:0] ID_NONE   = '1;
  localparam logic [IDX_W:0] ID_BORDER = {ID_NOSPR, {IDX_W{1'b0}}};

  spr_cfg_t [NUM_OBJ-1:0]              shadow, shadow_nxt;
  logic     [NUM_OBJ-1:0]              hit2, coll_now, acc;
  logic     [NUM_OBJ-1:0][COLOR_W-1:0] col2;
  logic     [COORD_W-1:0]              px1, py1;
  logic                                border2, armed;
  logic                                nxt_on;
  logic     [COLOR_W-1:0]              nxt_col;
  logic     [IDX_W:0]                  nxt_id;

  // Shadow config; shadow_nxt feeds the commit so a write coinciding
  // with frame_start goes straight through.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NUM_OBJ; i++)
      if (cfg_we && cfg_idx == IDX_W'(i))
        shadow_nxt[i] = '{x: cfg_x, y: cfg_y, color: cfg_color, en: cfg_en};
  end

  always_ff @(posedge clk) begin
    if (rst) shadow <= '0;
    else     shadow <= shadow_nxt;
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_spr
    sprite_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .clk      (clk),
      .rst      (rst),
      .commit   (frame_start),
      .cfg_nxt  (shadow_nxt[g]),
      .pixel_x  (pixel_x),
      .pixel_y  (pixel_y),
      .bmp_we   (bmp_we && bmp_idx == IDX_W'(g)),
      .bmp_row  (bmp_row),
      .bmp_data (bmp_data),
      .hit      (hit2[g]),
      .color    (col2[g])
    );
  end

  // Border runs alongside the sprite pipe: S1 pixel, S2 flag
  always_ff @(posedge clk) begin
    px1 <= pixel_x;
    py1 <= pixel_y;
  end

  always_ff @(posedge clk) begin
    if (rst) border2 <= 1'b0;
    else     border2 <= (BORDER_EN != 0) &&
                        (px1 == '0 || px1 == COORD_W'(MAX_X-1) ||
                         py1 == '0 || py1 == COORD_W'(MAX_Y-1));
  end

  // S3: descending scan so the lowest hit index is written last and wins
  always_comb begin
    nxt_on  = 1'b0;
    nxt_col = BLACK;
    nxt_id  = ID_NONE;
    if (border2) begin
      nxt_on  = 1'b1;
      nxt_col = WHITE;
      nxt_id  = ID_BORDER;
    end
    for (int i = NUM_OBJ-1; i >= 0; i--)
      if (hit2[i]) begin
        nxt_on  = 1'b1;
        nxt_col = col2[i];
        nxt_id  = {1'b0, IDX_W'(i)};
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      object_on    <= 1'b0;
      object_color <= BLACK;
      object_id    <= ID_NONE;
    end else begin
      object_on    <= nxt_on;
      object_color <= nxt_col;
      object_id    <= nxt_id;
    end
  end

  // x & (x-1) is nonzero exactly when two or more hit bits are set
  assign coll_now = ((hit2 & (hit2 - NUM_OBJ'(1))) != '0) ? hit2 : '0;

  // armed holds off the first report after reset, since that window
  // spans a partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      acc             <= '0;
      collision_mask  <= '0;
      collision_valid <= 1'b0;
      armed           <= 1'b0;
    end else begin
      collision_valid <= frame_start && armed;
      if (frame_start) begin
        acc   <= '0;
        armed <= 1'b1;
        if (armed) collision_mask <= acc | coll_now;
      end else begin
        acc <= acc | coll_now;
      end
    end
  end
endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: each driven pixel pushes its
// expected {on, color, id} from a behavioural model; a monitor pops and
// compares 3 cycles later. Collision reporting is checked per cycle.
module tb_sprite_renderer;
  localparam logic [2:0] C_BLACK = 3'b000, C_BLUE = 3'b001, C_GREEN = 3'b010,
                         C_YELLOW = 3'b110, C_WHITE = 3'b111;
  localparam logic [2:0] ID_NONE = 3'b111, ID_BORDER = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic       frame_start = 1'b0;
  logic       cfg_we = 1'b0, cfg_en = 1'b0;
  logic [1:0] cfg_idx = '0, bmp_idx = '0;
  logic [9:0] cfg_x = '0, cfg_y = '0;
  logic [2:0] cfg_color = '0, bmp_row = '0;
  logic       bmp_we = 1'b0;
  logic [7:0] bmp_data = '0;
  logic       object_on;
  logic [2:0] object_color;
  logic [2:0] object_id;
  logic [3:0] collision_mask;
  logic       collision_valid;

  always #5 clk = ~clk;

  sprite_renderer dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_color(cfg_color), .cfg_en(cfg_en),
    .bmp_we(bmp_we), .bmp_idx(bmp_idx), .bmp_row(bmp_row), .bmp_data(bmp_data),
    .object_on(object_on), .object_color(object_color), .object_id(object_id),
    .collision_mask(collision_mask), .collision_valid(collision_valid)
  );

  typedef struct packed { logic on; logic [2:0] col; logic [2:0] id; } exp_t;
  exp_t  q[$];
  string tq[$];
  int    n_vec = 0, n_err = 0;
  logic  drv_vld = 1'b0;
  logic [2:0] vp = '0;

  // behavioural model state: active and shadow config, bitmaps, collisions
  int         ax[4], ay[4], ac[4], sx[4], sy[4], sc[4];
  bit         ae[4], se[4];
  logic [7:0] mb[4][8];
  bit         armed;
  logic [3:0] m_acc, h1, h2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      ax[i] = 0; ay[i] = 0; ac[i] = 0; ae[i] = 0;
      sx[i] = 0; sy[i] = 0; sc[i] = 0; se[i] = 0;
      for (int r = 0; r < 8; r++) mb[i][r] = 8'h00;
    end
    armed = 0; m_acc = '0; h1 = '0; h2 = '0;
  endtask

  function automatic void model(input int px, input int py, output exp_t e,
                                output logic [3:0] hits);
    bit found;
    hits = '0;
    for (int i = 0; i < 4; i++)
      if (ae[i] && px >= ax[i] && px <= ax[i] + 7 && py >= ay[i] && py <= ay[i] + 7)
        if (mb[i][py - ay[i]][px - ax[i]]) hits[i] = 1'b1;
    e = '{1'b0, C_BLACK, ID_NONE};
    if (px == 0 || px == 639 || py == 0 || py == 479) e = '{1'b1, C_WHITE, ID_BORDER};
    found = 0;
    for (int i = 0; i < 4; i++)
      if (!found && hits[i]) begin
        found = 1;
        e = '{1'b1, 3'(ac[i]), {1'b0, 2'(i)}};
      end
  endfunction

  // One pixel clock: drive pixel plus any pending strobes, update model
  task automatic step(input int px, input int py, input bit fs = 1'b0);
    exp_t e;
    logic [3:0] hits, cur, exp_mask;
    bit exp_v;
    pixel_x = 10'(px); pixel_y = 10'(py); frame_start = fs; drv_vld = 1'b1;
    if (bmp_we) mb[bmp_idx][bmp_row] = bmp_data;
    model(px, py, e, hits);
    q.push_back(e);
    tq.push_back($sformatf("pix(%0d,%0d)", px, py));
    cur = ($countones(hits) >= 2) ? hits : 4'h0;
    exp_v = fs && armed;
    exp_mask = m_acc | h2;
    if (fs) m_acc = '0; else m_acc = m_acc | h2;
    h2 = h1; h1 = cur;
    if (cfg_we) begin
      sx[cfg_idx] = cfg_x; sy[cfg_idx] = cfg_y; sc[cfg_idx] = cfg_color; se[cfg_idx] = cfg_en;
    end
    if (fs) begin
      ax = sx; ay = sy; ac = sc; ae = se; armed = 1;
    end
    @(posedge clk); #1;
    chk("coll_valid", collision_valid, exp_v);
    if (exp_v) chk("coll_mask", collision_mask, exp_mask);
    cfg_we = 1'b0; bmp_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic set_cfg(input int i, input int x, input int y, input logic [2:0] c, input bit en);
    cfg_we = 1'b1; cfg_idx = 2'(i); cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_color = c; cfg_en = en;
  endtask

  task automatic load_bmp(input int i, input logic [7:0] row0, input logic [7:0] rest);
    for (int r = 0; r < 8; r++) begin
      bmp_we = 1'b1; bmp_idx = 2'(i); bmp_row = 3'(r);
      bmp_data = (r == 0) ? row0 : rest;
      step(1, 1);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 1);
  endtask

  task automatic do_reset();
    drv_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); tq.delete();
    model_clear();
    chk("rst_on", object_on, 1'b0);
    chk("rst_color", object_color, C_BLACK);
    chk("rst_id", object_id, ID_NONE);
    chk("rst_mask", collision_mask, 4'h0);
    chk("rst_valid", collision_valid, 1'b0);
  endtask

  always @(posedge clk) begin
    if (rst) vp <= '0;
    else     vp <= {vp[1:0], drv_vld};
  end

  exp_t  mon_e;
  string mon_t;
  always @(negedge clk) begin
    if (vp[2]) begin
      if (q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
      else begin
        mon_e = q.pop_front();
        mon_t = tq.pop_front();
        chk(mon_t, {object_on, object_color, object_id}, mon_e);
      end
    end
  end

  initial begin
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // single sprite, full bitmap; first frame_start after reset is silent
    load_bmp(0, 8'hFF, 8'hFF);
    set_cfg(0, 100, 50, C_GREEN, 1);
    step(1, 1, 1);
    step(100, 50); step(108, 50); step(107, 57); step(99, 50); step(100, 58);
    idle(3);

    // bitmap mask: row 0 = 00111100
    load_bmp(1, 8'b0011_1100, 8'h00);
    set_cfg(1, 200, 200, C_BLUE, 1);
    step(1, 1, 1);
    for (int x = 200; x < 208; x++) step(x, 200);
    idle(3);

    // priority and collision
    load_bmp(2, 8'hFF, 8'hFF);
    set_cfg(0, 296, 296, C_GREEN, 1);
    step(1, 1);
    set_cfg(2, 300, 300, C_YELLOW, 1);
    step(1, 1, 1);
    step(300, 300); step(303, 303); step(304, 304); step(299, 299);
    idle(3);
    step(1, 1, 1);
    idle(2);

    // shadow commit and same-cycle write-through
    load_bmp(3, 8'hFF, 8'hFF);
    set_cfg(3, 20, 400, C_BLUE, 1);
    step(1, 1, 1);
    step(20, 400);
    set_cfg(3, 10, 400, C_BLUE, 1);
    step(20, 400); step(10, 400);
    step(1, 1, 1);
    step(10, 400); step(20, 400);
    set_cfg(3, 30, 400, C_BLUE, 1);
    step(30, 400, 1);
    step(30, 400);
    idle(3);

    // border
    step(0, 17); step(639, 17); step(5, 479); step(1, 1); step(639, 479);
    idle(3);

    // reset mid-frame with all sprites enabled and overlapping
    for (int i = 0; i < 4; i++) begin
      set_cfg(i, 50, 100, 3'(i + 1), 1);
      step(1, 1);
    end
    step(1, 1, 1);
    step(50, 100); step(53, 104); step(51, 101);
    do_reset();
    step(50, 100); step(53, 104);
    idle(3);
    step(1, 1, 1);
    step(50, 100);
    idle(3);
    step(1, 1, 1);

    drv_vld = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Parametrised pixel renderer for the ping-pong VGA path. It replaces a fixed wall/bar/ball renderer with NUM_OBJ generic rectangular sprites. Each sprite has a runtime-loaded position, colour, enable and per-row bitmap, plus an optional white screen border, and all sprite parameters are frame-synchronised. It sits between the VGA sync generator (pixel_x/pixel_y) and the RGB output register, and also reports per-frame sprite collisions to the game-logic FSM.

## Interface
- NUM_OBJ, 4: number of sprites; index 0 has highest draw priority.
- SPR_W, 8: sprite width in pixels; power of 2, ≥2.
- SPR_H, 8: sprite height in pixels; power of 2, ≥2.
- COORD_W, 10: pixel and position coordinate width.
- COLOR_W, 3: colour width.
- MAX_X, 640 / MAX_Y, 480: visible area.
- BORDER_EN, 1: draw the 1-pixel border at x=0, x=MAX_X-1, y=0, y=MAX_Y-1.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- pixel_x, pixel_y  in  COORD_W  current scan position
- frame_start  in  1  one-cycle pulse; commits config and closes the collision window
- cfg_we  in  1  shadow config write strobe
- cfg_idx  in  clog2(NUM_OBJ)  sprite selected for the config write
- cfg_x, cfg_y  in  COORD_W  sprite top-left corner
- cfg_color  in  COLOR_W  sprite colour
- cfg_en  in  1  sprite visible
- bmp_we  in  1  bitmap row write strobe
- bmp_idx  in  clog2(NUM_OBJ)  sprite selected for the bitmap write
- bmp_row  in  clog2(SPR_H)  bitmap row
- bmp_data  in  SPR_W  row bits; bit 0 is the leftmost pixel
- object_on  out  1  some sprite or border covers the pixel
- object_color  out  COLOR_W  winning colour; BLACK when nothing covers the pixel
- object_id  out  clog2(NUM_OBJ)+1  MSB=1 means border or none; otherwise the winning sprite index
- collision_mask  out  NUM_OBJ  per sprite: overlapped another sprite during the last frame
- collision_valid  out  1  one-cycle pulse when collision_mask updates

## Operation
- **Config registers.** Each sprite has shadow {x, y, color, en}, written by cfg_we. On frame_start, every active register loads its shadow. A cfg_we in the same cycle as frame_start is included in the commit (write-through).
- **Bitmaps.** Bitmaps are single-buffered and written immediately by bmp_we; software writes them during blanking.
- **Hit test.** Sprite i is hit when all of the following hold:
  - en is set;
  - x ≤ pixel_x ≤ x+SPR_W-1 and y ≤ pixel_y ≤ y+SPR_H-1, with bounds computed at COORD_W+1 bits so they cannot wrap;
  - bitmap[i][pixel_y-y][pixel_x-x] = 1.
- **Priority.** The lowest hit index wins. If no sprite is hit, the border applies (WHITE, id = {1, 0…}). Otherwise the output is background: BLACK, object_on=0, id = all ones.
- **Collision accumulation.** In any cycle where ≥2 sprites are hit, OR those sprites' hit bits into an accumulator. The border never counts.
- **Collision window.** On frame_start: collision_mask ← accumulator | the current-cycle hits; accumulator ← 0; collision_valid pulses.

## Timing
- Latency is exactly 3 cycles from pixel_x/pixel_y to object_on, object_color and object_id.
- There is no back-pressure; the block accepts one pixel per cycle.
- Pipeline stages:
  - S1: register the pixel and compute the x/y offsets.
  - S2: per-sprite bounds compare, bitmap bit fetch, and hit[i].
  - S3: priority mux into the output registers.
- **Reset values.**
  - Outputs: object_on=0, object_color=BLACK, object_id=all ones, collision_mask=0, collision_valid=0.
  - Internal state: all shadow and active en=0, x=y=0, color=0; bitmaps all 0; accumulator 0.
- Pipeline registers after reset are don't-care for 3 cycles. The outputs are reset directly, so they are valid immediately.
- **Commit timing.** Config committed at frame_start in cycle t applies to pixels sampled at t+1 onward.
- **Reset mid-frame** clears all config. The collision_valid pulse is suppressed until the first frame_start after reset.
- **Right/bottom edge.** Sprites with x+SPR_W-1 ≥ MAX_X are clipped by the sync generator's range; no wrap to x=0.

## Structure
- Package render_pkg holds:
  - colour constants (BLACK=3'b000, BLUE, GREEN, YELLOW, WHITE=3'b111);
  - the object_id "none" and "border" encodings;
  - the typedef for the sprite config struct {x, y, color, en}.
- Sub-module sprite_hit, one instance per sprite, holds the active config and bitmap and produces a registered hit at S2.
- The top level holds the shadow registers, border detect, priority encoder and collision logic.

## Test plan
- **Single sprite.** Sprite 0 at (100,50), color GREEN, bitmap all ones, commit. Scan (100,50) → 3 cycles later object_on=1, color=GREEN, id=0. Pixel (108,50) → off.
- **Bitmap mask.** Sprite 1 row 0 = 8'b00111100 at (200,200). Pixels x=200..207 at y=200 → on only at x=202..205.
- **Priority and collision.** Sprites 0 and 2 overlap at (300,300). Output shows sprite 0's colour and id=0. At the next frame_start → collision_mask=4'b0101 and collision_valid pulses once.
- **Shadow commit.** Write sprite 3 x=10 mid-frame → still drawn at its old x until frame_start. A write in the same cycle as frame_start applies immediately.
- **Border.** pixel (0,17), (639,17), (5,479), no sprites → WHITE, id=border. Pixel (1,1) → BLACK, object_on=0.
- **Reset mid-frame** with all sprites enabled → object_on=0 from the next cycle. No sprite is drawn and no collision_valid pulse occurs after the following frame_start.
